// File: rtl/syst_apb.sv
// syst_apb: APB-attached 4-tap systolic FIR engine.
//
// Samples written to DATA_IN enter a NTAPS-stage systolic pipeline; each
// stage adds one coefficient*sample product to a travelling partial sum.
// Finished results land in a FIFO_DEPTH-entry result FIFO that software pops
// by reading RESULT. Zero-wait-state APB slave.
//
// Ports:
//   p_clk_i     APB clock, rising edge
//   p_rst_i     asynchronous active-low reset
//   p_sel_i     slave select
//   p_enable_i  access phase
//   p_we_i      1 = write, 0 = read
//   p_adr_i     byte address, decoded on [4:2]; other bits must be 0
//   p_dat_i     write data
//   p_dat_o     combinational read data (0 unless selected read)
//   p_ready     combinational transfer complete (p_sel_i & p_enable_i)
//
// Build option:
//   SYST_APB_SAT_EN  when defined, accumulation saturates to the signed
//                    32-bit range; otherwise it wraps.
//
// Register map (byte offsets):
//   0x00 DATA_IN  W   0x04 RESULT R (pops)   0x08..0x14 COEF0..3 RW
//   0x18 STATUS   R   0x1C CTRL W (bit0 flush, bit1 clear flags)

module syst_apb #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned NTAPS      = 4
) (
  input  logic        p_clk_i,
  input  logic        p_rst_i,
  input  logic        p_sel_i,
  input  logic        p_enable_i,
  input  logic        p_we_i,
  input  logic [31:0] p_adr_i,
  input  logic [31:0] p_dat_i,
  output logic [31:0] p_dat_o,
  output logic        p_ready
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_RESULT = 3'd1;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_CTRL   = 3'd7;

  // A 16x16 signed product always fits in 32 bits, so only the sum can overflow.
  function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = $signed({{16{a[15]}}, a});
    sb = $signed({{16{b[15]}}, b});
    return sa * sb;
  endfunction

  // Partial-sum accumulation, saturating or wrapping depending on the build.
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b);
`ifdef SYST_APB_SAT_EN
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
`else
    return a + b;
`endif
  endfunction

  // Register state
  logic [15:0]      r_coef [NTAPS];
  logic [15:0]      r_hist [NTAPS];
  logic [NTAPS-1:0] r_sv;
  logic [31:0]      r_ps   [NTAPS];
  logic [15:0]      r_sx   [NTAPS][NTAPS];
  logic [31:0]      r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_udf;

  // Decode
  logic        w_access;
  logic        w_mapped;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_data_wr;
  logic        w_res_rd;
  logic        w_ctrl_wr;
  logic        w_clr_pipe;
  logic        w_clr_flag;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_udf;
  logic        w_push;
  logic        w_push_ok;
  logic        w_ovf;
  logic [31:0] w_push_data;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_access   = p_sel_i & p_enable_i;
  assign w_mapped   = (p_adr_i[31:5] == 27'd0) && (p_adr_i[1:0] == 2'd0);
  assign w_idx      = p_adr_i[4:2];
  assign w_wr       = w_access & p_we_i & w_mapped;
  assign w_rd       = w_access & ~p_we_i & w_mapped;
  assign w_data_wr  = w_wr && (w_idx == A_DATA);
  assign w_res_rd   = w_rd && (w_idx == A_RESULT);
  assign w_ctrl_wr  = w_wr && (w_idx == A_CTRL);
  assign w_clr_pipe = w_ctrl_wr & p_dat_i[0];
  assign w_clr_flag = w_ctrl_wr & p_dat_i[1];

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = w_res_rd & ~w_empty;
  assign w_udf   = w_res_rd & w_empty;

  // Last PE output feeds the FIFO directly; a pop frees a slot on the same edge.
  assign w_push      = r_sv[NTAPS-1];
  assign w_push_data = acc_add(r_ps[NTAPS-1], mul16(r_coef[NTAPS-1], r_sx[NTAPS-1][NTAPS-1]));
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_ovf       = w_push & w_full & ~w_pop;

  assign p_ready = p_sel_i & p_enable_i;

  // Upper write-data bits carry no register fields.
  assign w_unused = ^p_dat_i[31:16];

  // Read mux
  always_comb begin
    w_rdata = '0;
    if (w_mapped) begin
      case (w_idx)
        A_RESULT: w_rdata = w_empty ? 32'd0 : r_fifo[r_rptr];
        A_STATUS: w_rdata = {22'd0, r_udf, r_ovf, 2'd0, w_full, w_empty, 4'(r_count)};
        default: begin
          for (int unsigned k = 0; k < NTAPS; k++) begin
            if (w_idx == 3'(k + 2)) w_rdata = {{16{r_coef[k][15]}}, r_coef[k]};
          end
        end
      endcase
    end
  end

  assign p_dat_o = (p_sel_i & ~p_we_i) ? w_rdata : 32'd0;

  // Coefficients, sample history, systolic pipeline, FIFO pointers and flags
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_coef[k] <= (k == 0) ? 16'd1 : 16'd0;
        r_hist[k] <= '0;
        r_ps[k]   <= '0;
        for (int j = 0; j < NTAPS; j++) r_sx[k][j] <= '0;
      end
      r_sv    <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        if (w_wr && (w_idx == 3'(k + 2))) r_coef[k] <= p_dat_i[15:0];
      end

      if (w_clr_pipe) begin
        // Flush drops history, every in-flight result and the FIFO contents.
        for (int k = 0; k < NTAPS; k++) r_hist[k] <= '0;
        r_sv    <= '0;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_data_wr) begin
          r_hist[0] <= p_dat_i[15:0];
          for (int k = 1; k < NTAPS; k++) r_hist[k] <= r_hist[k-1];
        end
        // Stage 0 snapshots the sample window x[n..n-NTAPS+1]; PE k consumes slot k.
        r_sv       <= {r_sv[NTAPS-2:0], w_data_wr};
        r_ps[0]    <= '0;
        r_sx[0][0] <= p_dat_i[15:0];
        for (int k = 1; k < NTAPS; k++) r_sx[0][k] <= r_hist[k-1];
        for (int k = 1; k < NTAPS; k++) begin
          r_ps[k] <= acc_add(r_ps[k-1], mul16(r_coef[k-1], r_sx[k-1][k-1]));
          r_sx[k] <= r_sx[k-1];
        end

        if (w_pop)     r_rptr <= r_rptr + PTR_W'(1);
        if (w_push_ok) r_wptr <= r_wptr + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
      end

      if (w_clr_flag) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        if (w_ovf && !w_clr_pipe) r_ovf <= 1'b1;
        if (w_udf)                r_udf <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge p_clk_i) begin
    if (w_push_ok && !w_clr_pipe) r_fifo[r_wptr] <= w_push_data;
  end

endmodule

// File: tb/tb_syst_apb.sv
`timescale 1ns/1ps
module tb_syst_apb;

  logic        p_clk_i    = 1'b0;
  logic        p_rst_i    = 1'b0;
  logic        p_sel_i    = 1'b0;
  logic        p_enable_i = 1'b0;
  logic        p_we_i     = 1'b0;
  logic [31:0] p_adr_i    = '0;
  logic [31:0] p_dat_i    = '0;
  logic [31:0] p_dat_o;
  logic        p_ready;

  localparam logic [31:0] A_DATA   = 32'h00;
  localparam logic [31:0] A_RESULT = 32'h04;
  localparam logic [31:0] A_COEF0  = 32'h08;
  localparam logic [31:0] A_STATUS = 32'h18;
  localparam logic [31:0] A_CTRL   = 32'h1C;

  syst_apb dut (
    .p_clk_i    (p_clk_i),
    .p_rst_i    (p_rst_i),
    .p_sel_i    (p_sel_i),
    .p_enable_i (p_enable_i),
    .p_we_i     (p_we_i),
    .p_adr_i    (p_adr_i),
    .p_dat_i    (p_dat_i),
    .p_dat_o    (p_dat_o),
    .p_ready    (p_ready)
  );

  always #5 p_clk_i = ~p_clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model / scoreboard
  int          m_coef [4];
  int          m_hist [4];
  logic [31:0] m_q [$];
  logic        m_ovf;
  logic        m_udf;

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic logic [31:0] model_y();
    longint acc;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc = acc + longint'(m_coef[k]) * longint'(m_hist[k]);
`ifdef SYST_APB_SAT_EN
      acc = clamp32(acc);
`endif
    end
    return acc[31:0];
  endfunction

  function automatic logic [31:0] model_status();
    logic [3:0] cnt;
    cnt = 4'(m_q.size());
    return {22'd0, m_udf, m_ovf, 2'd0, (m_q.size() == 8), (m_q.size() == 0), cnt};
  endfunction

  task automatic model_reset();
    m_coef = '{1, 0, 0, 0};
    m_hist = '{0, 0, 0, 0};
    m_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  task automatic sb_pop(output logic [31:0] e);
    if (m_q.size() == 0) begin
      e = 32'd0;
      m_udf = 1'b1;
    end else begin
      e = m_q.pop_front();
    end
  endtask

  // APB transfers start right after a clock edge; setup begins immediately.
  task automatic apb_write(input logic [31:0] adr, input logic [31:0] dat, output logic rdy);
    p_sel_i = 1'b1; p_enable_i = 1'b0; p_we_i = 1'b1; p_adr_i = adr; p_dat_i = dat;
    @(posedge p_clk_i); #1;
    p_enable_i = 1'b1;
    #1 rdy = p_ready;
    @(posedge p_clk_i); #1;
    p_sel_i = 1'b0; p_enable_i = 1'b0; p_we_i = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] adr, output logic [31:0] dat, output logic rdy);
    p_sel_i = 1'b1; p_enable_i = 1'b0; p_we_i = 1'b0; p_adr_i = adr;
    @(posedge p_clk_i); #1;
    p_enable_i = 1'b1;
    #1;
    rdy = p_ready;
    dat = p_dat_o;
    @(posedge p_clk_i); #1;
    p_sel_i = 1'b0; p_enable_i = 1'b0;
  endtask

  task automatic wr_sample(input logic [31:0] v);
    logic r;
    apb_write(A_DATA, v, r);
    m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0];
    m_hist[0] = int'($signed(v[15:0]));
    if (m_q.size() == 8) m_ovf = 1'b1;
    else m_q.push_back(model_y());
  endtask

  task automatic wr_coef(input int k, input logic [31:0] v);
    logic r;
    apb_write(A_COEF0 + 32'(4 * k), v, r);
    m_coef[k] = int'($signed(v[15:0]));
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic r;
    apb_write(A_CTRL, v, r);
    if (v[0]) begin
      m_hist = '{0, 0, 0, 0};
      m_q.delete();
    end
    if (v[1]) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge p_clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    logic r;
    p_rst_i = 1'b0;
    repeat (3) @(posedge p_clk_i);
    #1;
    n_checks++;
    if (p_ready !== 1'b0 || p_dat_o !== 32'd0) begin
      n_errors++; $display("FAIL reset_outputs: ready=%b dat=%h required ready=0 dat=0", p_ready, p_dat_o);
    end
    p_rst_i = 1'b1;
    model_reset();
    idle(1);
    p_sel_i = 1'b1; p_we_i = 1'b0; p_enable_i = 1'b0; p_adr_i = A_STATUS;
    #1;
    n_checks++;
    if (p_ready !== 1'b0) begin
      n_errors++; $display("FAIL setup_ready: got %b required 0", p_ready);
    end
    p_sel_i = 1'b0;
    #1;
    n_checks++;
    if (p_ready !== 1'b0) begin
      n_errors++; $display("FAIL idle_ready: got %b required 0", p_ready);
    end
    apb_read(A_STATUS, d, r);
    n_checks++;
    if (d !== 32'h0000_0010 || d !== model_status()) begin
      n_errors++; $display("FAIL reset_status: got %h required %h", d, 32'h10);
    end
    apb_read(A_COEF0, d, r);
    n_checks++;
    if (d !== 32'h0000_0001) begin
      n_errors++; $display("FAIL reset_coef0: got %h required 00000001", d);
    end
    apb_read(A_COEF0 + 32'd4, d, r);
    e = 32'(m_coef[1]);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL reset_coef1: got %h required %h", d, e);
    end
  endtask

  task automatic test_passthrough();
    logic [31:0] d, e;
    logic r;
    wr_sample(32'h0000_1234);
    wr_sample(32'hFFFF_8000);
    idle(5);
    for (int i = 0; i < 2; i++) begin
      apb_read(A_RESULT, d, r);
      sb_pop(e);
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL passthrough_result%0d: got %h required %h", i, d, e);
      end
    end
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL passthrough_status: got %h required %h", d, e);
    end
  endtask

  // Peeks STATUS during setup phases (no transfer completes) to time the pipeline.
  task automatic test_latency();
    logic [31:0] d, e;
    logic [3:0]  exp_cnt;
    logic r;
    wr_sample(32'h0000_0042);
    p_sel_i = 1'b1; p_we_i = 1'b0; p_enable_i = 1'b0; p_adr_i = A_STATUS;
    for (int i = 0; i <= 4; i++) begin
      #1;
      exp_cnt = (i == 4) ? 4'd1 : 4'd0;
      n_checks++;
      if (p_dat_o[3:0] !== exp_cnt) begin
        n_errors++; $display("FAIL latency_cycle%0d: count %0d required %0d", i, p_dat_o[3:0], exp_cnt);
      end
      if (i < 4) @(posedge p_clk_i);
    end
    p_sel_i = 1'b0;
    apb_read(A_RESULT, d, r);
    sb_pop(e);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL latency_result: got %h required %h", d, e);
    end
  endtask

  task automatic test_fir();
    logic [31:0] d, e;
    logic r;
    wr_ctrl(32'h1);
    for (int k = 0; k < 4; k++) wr_coef(k, 32'(k + 1));
    for (int i = 0; i < 4; i++) wr_sample(32'd1);
    idle(5);
    for (int i = 0; i < 4; i++) begin
      apb_read(A_RESULT, d, r);
      sb_pop(e);
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL fir_result%0d: got %h required %h", i, d, e);
      end
    end
  endtask

  task automatic test_ctrl_flush();
    logic [31:0] d, e;
    logic r;
    wr_sample(32'd7);
    wr_sample(32'd9);
    wr_ctrl(32'h1);
    idle(6);
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL flush_status: got %h required %h", d, e);
    end
    wr_sample(32'd5);
    idle(5);
    apb_read(A_RESULT, d, r);
    sb_pop(e);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL flush_history: got %h required %h", d, e);
    end
  endtask

  task automatic test_fifo_boundary();
    logic [31:0] d, e;
    logic r;
    wr_ctrl(32'h3);
    wr_coef(0, 32'd1); wr_coef(1, 32'd0); wr_coef(2, 32'd0); wr_coef(3, 32'd0);
    for (int i = 0; i < 9; i++) wr_sample(32'((i + 1) * 32'h111));
    idle(6);
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e || d !== 32'h0000_0128) begin
      n_errors++; $display("FAIL fifo_full_status: got %h required %h", d, e);
    end
    for (int i = 0; i < 10; i++) begin
      apb_read(A_RESULT, d, r);
      sb_pop(e);
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL fifo_read%0d: got %h required %h", i, d, e);
      end
    end
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL fifo_flags_status: got %h required %h", d, e);
    end
    wr_ctrl(32'h2);
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e || d !== 32'h0000_0010) begin
      n_errors++; $display("FAIL fifo_flag_clear: got %h required %h", d, e);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] d, e, lit;
    logic r;
`ifdef SYST_APB_SAT_EN
    lit = 32'h7FFF_FFFF;
`else
    lit = 32'hFFFC_0004;
`endif
    wr_ctrl(32'h1);
    for (int k = 0; k < 4; k++) wr_coef(k, 32'h7FFF);
    for (int i = 0; i < 4; i++) wr_sample(32'h7FFF);
    idle(5);
    for (int i = 0; i < 4; i++) begin
      apb_read(A_RESULT, d, r);
      sb_pop(e);
      n_checks++;
      if (d !== e) begin
        n_errors++; $display("FAIL sat_result%0d: got %h required %h", i, d, e);
      end
      if (i == 3) begin
        n_checks++;
        if (d !== lit) begin
          n_errors++; $display("FAIL sat_final: got %h required %h", d, lit);
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] d, e;
    logic [31:0] wadr [3];
    logic [31:0] radr [3];
    logic r;
    wadr = '{32'h20, 32'h3C, 32'h09};
    radr = '{32'h20, 32'h02, 32'h1A};
    wr_sample(32'h0000_0033);
    idle(5);
    for (int i = 0; i < 3; i++) begin
      apb_write(wadr[i], 32'h0000_0003, r);
      n_checks++;
      if (r !== 1'b1) begin
        n_errors++; $display("FAIL unmapped_wr_ready%0d: got %b required 1", i, r);
      end
    end
    for (int i = 0; i < 3; i++) begin
      apb_read(radr[i], d, r);
      n_checks++;
      if (d !== 32'd0 || r !== 1'b1) begin
        n_errors++; $display("FAIL unmapped_read%0d: data %h ready %b required 00000000 1", i, d, r);
      end
    end
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL unmapped_status: got %h required %h", d, e);
    end
    apb_read(A_COEF0, d, r);
    e = 32'(m_coef[0]);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL unmapped_coef0: got %h required %h", d, e);
    end
    apb_read(A_RESULT, d, r);
    sb_pop(e);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL unmapped_result: got %h required %h", d, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic r;
    wr_sample(32'h10);
    wr_sample(32'h20);
    #3 p_rst_i = 1'b0;
    repeat (2) @(posedge p_clk_i);
    #3 p_rst_i = 1'b1;
    model_reset();
    idle(8);
    apb_read(A_STATUS, d, r);
    e = model_status();
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL midreset_status: got %h required %h", d, e);
    end
    apb_read(A_COEF0, d, r);
    e = 32'(m_coef[0]);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL midreset_coef0: got %h required %h", d, e);
    end
    apb_read(A_RESULT, d, r);
    sb_pop(e);
    n_checks++;
    if (d !== e) begin
      n_errors++; $display("FAIL midreset_result: got %h required %h", d, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_passthrough();
    test_latency();
    test_fir();
    test_ctrl_flush();
    test_fifo_boundary();
    test_saturation();
    test_unmapped();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
